max_fwd_arbiter: RTL and testbench

Shares one `max_forwarding` pipeline between `NUM_REQ` softmax row requesters. Each requester streams max beats (local max, length mode, flat input row) into the pipeline. The arbiter never interleaves the beats of a grouped row, drives the pipeline enable, and tags every accepted beat so the pipeline result returns with its requester ID. It sits between the per-head local-max trees and the shared `max_forwarding` instance.

---
 rtl/max_fwd_pkg.sv | 24 ++
 rtl/max_fwd_tag_pipe.sv | 50 +++++
 rtl/max_fwd_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_max_fwd_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_fwd_pkg.sv
// Shared definitions for the max_forwarding arbiter slice.
//   - MAX_FWD_LAT : latency of the shared max_forwarding pipeline (enabled cycles)
//   - arb_state_e : arbiter FSM state
//   - mode_is_grouped / mode_beats : length-mode decode (beats per row)
package max_fwd_pkg;

  localparam int unsigned MAX_FWD_LAT = 12;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Modes 3..13 carry a row split over several beats; all others are single beats.
  function automatic logic mode_is_grouped(input logic [3:0] mode);
    return (mode >= 4'd3) && (mode <= 4'd13);
  endfunction

  // Beats per row: mode-1 for grouped modes (2..12), otherwise 1.
  function automatic logic [3:0] mode_beats(input logic [3:0] mode);
    return mode_is_grouped(mode) ? (mode - 4'd1) : 4'd1;
  endfunction

endpackage

// File: rtl/max_fwd_tag_pipe.sv
// Enable-gated {valid, id} delay line that tracks beats through the shared
// max_forwarding pipeline so each result can be returned to its requester.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears all tags)
//   i_en           : advance the line by one stage
//   i_valid, i_id  : tag entering stage 0
//   o_valid, o_id  : tag at the tail (stage LAT-1)
module max_fwd_tag_pipe #(
  parameter int unsigned LAT  = 12,
  parameter int unsigned ID_W = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_valid,
  input  logic [ID_W-1:0] i_id,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id
);

  logic [LAT-1:0]           valid_q, valid_d;
  logic [LAT-1:0][ID_W-1:0] id_q, id_d;

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    if (i_en) begin
      valid_d[0] = i_valid;
      id_d[0]    = i_id;
      for (int unsigned s = 1; s < LAT; s++) begin
        valid_d[s] = valid_q[s-1];
        id_d[s]    = id_q[s-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign o_valid = valid_q[LAT-1];
  assign o_id    = id_q[LAT-1];

endmodule

// File: rtl/max_fwd_arbiter.sv
// Shares one max_forwarding pipeline between NUM_REQ softmax row requesters.
// Grouped rows are locked to their owner until all beats have transferred;
// every accepted beat is tagged so the result returns with its requester ID.
// Build option: define MAX_FWD_ARB_RR_EN for round-robin winner selection;
// otherwise the lowest valid index wins and no pointer is kept.
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_req_*/o_req_ready     : per-requester beat handshake and payload
//   o_en, o_valid_max, o_*  : pipeline enable and muxed beat
//   i_pipe_valid/global_max : pipeline result
//   o_rsp_*/i_rsp_ready     : tagged result to the consumer (ready low stalls)
//   o_proto_err             : sticky protocol error
module max_fwd_arbiter
  import max_fwd_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 1024,
  parameter int unsigned LAT     = MAX_FWD_LAT
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic [NUM_REQ*16-1:0]        i_req_loc_max,
  input  logic [NUM_REQ*4-1:0]         i_req_length_mode,
  input  logic [NUM_REQ*DATA_W-1:0]    i_req_in_flat,
  output logic                         o_en,
  output logic                         o_valid_max,
  output logic [15:0]                  o_loc_max,
  output logic [3:0]                   o_length_mode,
  output logic [DATA_W-1:0]            o_in_flat,
  input  logic                         i_pipe_valid,
  input  logic [15:0]                  i_pipe_global_max,
  output logic                         o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   o_rsp_id,
  output logic [15:0]                  o_rsp_global_max,
  input  logic                         i_rsp_ready,
  output logic                         o_proto_err
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [3:0]      remaining_q, remaining_d;
  logic [3:0]      lock_mode_q, lock_mode_d;
  logic            proto_err_q, proto_err_d;

  logic [ID_W-1:0] win_idx;
  logic            win_any;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  logic            gap_freeze;
  logic            en;
  logic            xfer;
  logic [3:0]      sel_mode;
  logic            tail_valid;
  logic [ID_W-1:0] tail_id;

`ifdef MAX_FWD_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_any && i_req_valid[wrap_add(ptr_q, i)]) begin
        win_any = 1'b1;
        win_idx = wrap_add(ptr_q, i);
      end
    end
  end
`else
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_any && i_req_valid[i]) begin
        win_any = 1'b1;
        win_idx = i[ID_W-1:0];
      end
    end
  end
`endif

  always_comb begin
    if (state_q == LOCKED) begin
      grant_any = 1'b1;
      grant_idx = owner_q;
    end else begin
      grant_any = win_any;
      grant_idx = win_idx;
    end
  end

  // Holding the pipeline while the owner pauses avoids inserting a bubble,
  // which would restart the pipeline's group counter mid-row.
  assign gap_freeze = (state_q == LOCKED) && !i_req_valid[owner_q];
  assign en         = i_rst_n && i_rsp_ready && !gap_freeze;
  assign xfer       = en && grant_any && i_req_valid[grant_idx];
  assign sel_mode   = i_req_length_mode[32'(grant_idx)*4 +: 4];

  always_comb begin
    o_req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      o_req_ready[i] = en && grant_any && (grant_idx == i[ID_W-1:0]);
    end
  end

  assign o_en          = en;
  assign o_valid_max   = xfer;
  assign o_loc_max     = xfer ? i_req_loc_max[32'(grant_idx)*16 +: 16] : '0;
  assign o_length_mode = xfer ? sel_mode : '0;
  assign o_in_flat     = xfer ? i_req_in_flat[32'(grant_idx)*DATA_W +: DATA_W] : '0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    remaining_d = remaining_q;
    lock_mode_d = lock_mode_q;
    proto_err_d = proto_err_q;
`ifdef MAX_FWD_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    if (xfer) begin
      if (state_q == IDLE) begin
        if (mode_is_grouped(sel_mode)) begin
          state_d     = LOCKED;
          owner_d     = grant_idx;
          remaining_d = mode_beats(sel_mode) - 4'd1;
          lock_mode_d = sel_mode;
        end else begin
`ifdef MAX_FWD_ARB_RR_EN
          ptr_d = wrap_add(grant_idx, 1);
`endif
        end
      end else begin
        remaining_d = remaining_q - 4'd1;
        if (remaining_q == 4'd1) begin
          state_d = IDLE;
`ifdef MAX_FWD_ARB_RR_EN
          ptr_d   = wrap_add(owner_q, 1);
`endif
        end
      end
    end
    if ((state_q == LOCKED) && i_req_valid[owner_q] && (sel_mode != lock_mode_q)) begin
      proto_err_d = 1'b1;
    end
    if (en && (tail_valid != i_pipe_valid)) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      remaining_q <= '0;
      lock_mode_q <= '0;
      proto_err_q <= 1'b0;
`ifdef MAX_FWD_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      remaining_q <= remaining_d;
      lock_mode_q <= lock_mode_d;
      proto_err_q <= proto_err_d;
`ifdef MAX_FWD_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  max_fwd_tag_pipe #(
    .LAT  (LAT),
    .ID_W (ID_W)
  ) u_tag_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (en),
    .i_valid (xfer),
    .i_id    (xfer ? grant_idx : '0),
    .o_valid (tail_valid),
    .o_id    (tail_id)
  );

  assign o_rsp_valid      = tail_valid && en;
  assign o_rsp_id         = tail_id;
  assign o_rsp_global_max = i_pipe_global_max;
  assign o_proto_err      = proto_err_q;

endmodule

// File: tb/tb_max_fwd_arbiter.sv
// Directed bench for max_fwd_arbiter (NUM_REQ=2, DATA_W=32, LAT=12).
// A small stand-in for the max_forwarding pipeline delays valid/loc_max by
// LAT enabled cycles; transfers and responses are logged at the falling edge
// and compared with hand-computed cycle/ID lists after each scenario.
module tb_max_fwd_arbiter;

  localparam int unsigned LAT = 12;
`ifdef MAX_FWD_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] loc_max;
  logic [7:0]  req_mode;
  logic [63:0] flat;
  logic        o_en, o_valid_max;
  logic [15:0] o_loc_max;
  logic [3:0]  o_length_mode;
  logic [31:0] o_in_flat;
  logic        pipe_valid;
  logic [15:0] pipe_gmax;
  logic        o_rsp_valid;
  logic [0:0]  o_rsp_id;
  logic [15:0] o_rsp_gmax;
  logic        rsp_ready;
  logic        o_proto_err;

  always #5 clk = ~clk;

  max_fwd_arbiter #(
    .NUM_REQ (2),
    .DATA_W  (32),
    .LAT     (LAT)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .i_req_loc_max     (loc_max),
    .i_req_length_mode (req_mode),
    .i_req_in_flat     (flat),
    .o_en              (o_en),
    .o_valid_max       (o_valid_max),
    .o_loc_max         (o_loc_max),
    .o_length_mode     (o_length_mode),
    .o_in_flat         (o_in_flat),
    .i_pipe_valid      (pipe_valid),
    .i_pipe_global_max (pipe_gmax),
    .o_rsp_valid       (o_rsp_valid),
    .o_rsp_id          (o_rsp_id),
    .o_rsp_global_max  (o_rsp_gmax),
    .i_rsp_ready       (rsp_ready),
    .o_proto_err       (o_proto_err)
  );

  // Stand-in pipeline: pure delay of LAT enabled cycles.
  logic [LAT-1:0]       stub_v;
  logic [LAT-1:0][15:0] stub_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_v <= '0;
      stub_m <= '0;
    end else if (o_en) begin
      stub_v <= {stub_v[LAT-2:0], o_valid_max};
      stub_m <= {stub_m[LAT-2:0], o_loc_max};
    end
  end
  assign pipe_valid = stub_v[LAT-1];
  assign pipe_gmax  = stub_m[LAT-1];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int t;

  int mon_x_cyc[$], mon_x_id[$];
  int mon_r_cyc[$], mon_r_id[$], mon_r_val[$];
  int exp_x_cyc[$], exp_x_id[$];
  int exp_r_cyc[$], exp_r_id[$], exp_r_val[$];

  always @(negedge clk) begin
    if (o_valid_max) begin
      mon_x_cyc.push_back(cyc);
      mon_x_id.push_back(req_ready == 2'b01 ? 0 : (req_ready == 2'b10 ? 1 : 9));
    end
    if (o_rsp_valid) begin
      mon_r_cyc.push_back(cyc);
      mon_r_id.push_back(int'(o_rsp_id));
      mon_r_val.push_back(int'(o_rsp_gmax));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_x(input int c, input int id);
    exp_x_cyc.push_back(c);
    exp_x_id.push_back(id);
  endtask

  task automatic push_r(input int c, input int id, input int v);
    exp_r_cyc.push_back(c);
    exp_r_id.push_back(id);
    exp_r_val.push_back(v);
  endtask

  task automatic compare_logs(input string name);
    check($sformatf("%s_nxfer", name), 32'(mon_x_cyc.size()), 32'(exp_x_cyc.size()));
    for (int i = 0; i < exp_x_cyc.size() && i < mon_x_cyc.size(); i++) begin
      check($sformatf("%s_x%0d_cyc", name, i), 32'(mon_x_cyc[i]), 32'(exp_x_cyc[i]));
      check($sformatf("%s_x%0d_id", name, i), 32'(mon_x_id[i]), 32'(exp_x_id[i]));
    end
    check($sformatf("%s_nrsp", name), 32'(mon_r_cyc.size()), 32'(exp_r_cyc.size()));
    for (int i = 0; i < exp_r_cyc.size() && i < mon_r_cyc.size(); i++) begin
      check($sformatf("%s_r%0d_cyc", name, i), 32'(mon_r_cyc[i]), 32'(exp_r_cyc[i]));
      check($sformatf("%s_r%0d_id", name, i), 32'(mon_r_id[i]), 32'(exp_r_id[i]));
      check($sformatf("%s_r%0d_val", name, i), 32'(mon_r_val[i]), 32'(exp_r_val[i]));
    end
    mon_x_cyc.delete(); mon_x_id.delete();
    mon_r_cyc.delete(); mon_r_id.delete(); mon_r_val.delete();
    exp_x_cyc.delete(); exp_x_id.delete();
    exp_r_cyc.delete(); exp_r_id.delete(); exp_r_val.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    req_mode  = 8'h00;
    loc_max   = {16'h00B1, 16'h00A0};
    flat      = {32'hBBBB0001, 32'hAAAA0000};

    // Reset: req0 valid but nothing may be granted.
    tick(); tick(); settle();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_vmax", 32'(o_valid_max), 32'd0);
    check("rst_en", 32'(o_en), 32'd0);
    check("rst_rspv", 32'(o_rsp_valid), 32'd0);
    check("rst_err", 32'(o_proto_err), 32'd0);
    check("rst_rspid", 32'(o_rsp_id), 32'd0);

    tick(); rst_n = 1'b1; t = cyc; settle();
    check("rel_ready", 32'(req_ready), 32'd1);
    check("rel_vmax", 32'(o_valid_max), 32'd1);
    check("rel_locmax", 32'(o_loc_max), 32'h00A0);
    push_x(t, 0); push_r(t + 12, 0, 16'h00A0);
    tick(); req_valid = 2'b00; settle();
    check("idle_vmax", 32'(o_valid_max), 32'd0);
    check("idle_locmax", 32'(o_loc_max), 32'd0);
    run(14);
    compare_logs("reset");

    // Group lock: req0 mode 5 (4 beats), req1 waits.
    tick(); t = cyc; req_mode = {4'd0, 4'd5}; req_valid = 2'b01; settle();
    check("lock_b0", 32'(req_ready), 32'd1);
    check("lock_mode", 32'(o_length_mode), 32'd5);
    tick(); req_valid = 2'b11; settle();
    check("lock_b1", 32'(req_ready), 32'd1);
    tick(); settle();
    check("lock_b2", 32'(req_ready), 32'd1);
    tick(); settle();
    check("lock_b3", 32'(req_ready), 32'd1);
    tick(); req_valid = 2'b10; settle();
    check("lock_sw", 32'(req_ready), 32'd2);
    check("lock_flat", o_in_flat, 32'hBBBB0001);
    tick(); req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      push_x(t + i, 0); push_r(t + i + 12, 0, 16'h00A0);
    end
    push_x(t + 4, 1); push_r(t + 16, 1, 16'h00B1);
    run(14);
    compare_logs("lock");

    // Gap freeze: req0 mode 4 (3 beats) pauses 3 cycles after beat 1.
    tick(); t = cyc; req_mode = {4'd0, 4'd4}; req_valid = 2'b01; settle();
    check("gap_b0", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); req_valid = 2'b10; settle();
      check($sformatf("gap_en%0d", i), 32'(o_en), 32'd0);
      check($sformatf("gap_rdy%0d", i), 32'(req_ready), 32'd0);
    end
    tick(); req_valid = 2'b11; settle();
    check("gap_b1", 32'(req_ready), 32'd1);
    tick(); settle();
    check("gap_b2", 32'(req_ready), 32'd1);
    tick(); req_valid = 2'b10; settle();
    check("gap_r1", 32'(req_ready), 32'd2);
    tick(); req_valid = 2'b00;
    push_x(t, 0); push_x(t + 4, 0); push_x(t + 5, 0); push_x(t + 6, 1);
    push_r(t + 15, 0, 16'h00A0); push_r(t + 16, 0, 16'h00A0);
    push_r(t + 17, 0, 16'h00A0); push_r(t + 18, 1, 16'h00B1);
    run(14);
    compare_logs("gap");

    // Backpressure while the first result is at the tail.
    tick(); t = cyc; req_mode = {4'd0, 4'd3}; req_valid = 2'b01;
    tick();
    tick(); req_valid = 2'b10;
    tick(); req_valid = 2'b00;
    run(8);
    tick(); rsp_ready = 1'b0; req_valid = 2'b10; settle();
    check("bp_rspv", 32'(o_rsp_valid), 32'd0);
    check("bp_en", 32'(o_en), 32'd0);
    check("bp_rdy", 32'(req_ready), 32'd0);
    tick(); settle();
    check("bp_vmax", 32'(o_valid_max), 32'd0);
    run(3);
    tick(); rsp_ready = 1'b1; req_valid = 2'b00; settle();
    check("bp_resume_v", 32'(o_rsp_valid), 32'd1);
    push_x(t, 0); push_x(t + 1, 0); push_x(t + 2, 1);
    push_r(t + 17, 0, 16'h00A0); push_r(t + 18, 0, 16'h00A0); push_r(t + 19, 1, 16'h00B1);
    run(4);
    compare_logs("bp");

    // Fairness: both requesters continuously valid with singleton mode 0.
    tick(); t = cyc; req_mode = 8'h00; req_valid = 2'b11; settle();
    check("fair_g0", 32'(req_ready), 32'd1);
    tick(); settle();
    check("fair_g1", 32'(req_ready), RR ? 32'd2 : 32'd1);
    tick(); tick(); tick(); req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      push_x(t + i, RR ? (i % 2) : 0);
      push_r(t + i + 12, RR ? (i % 2) : 0, (RR && (i % 2 == 1)) ? 16'h00B1 : 16'h00A0);
    end
    run(14);
    compare_logs("fair");
    check("fair_noerr", 32'(o_proto_err), 32'd0);

    // Protocol error: req0 changes mode 6 -> 7 while locked; then reset mid-group.
    tick(); t = cyc; req_mode = {4'd0, 4'd6}; req_valid = 2'b01; settle();
    check("perr_b0", 32'(req_ready), 32'd1);
    tick(); req_mode = {4'd0, 4'd7}; settle();
    check("perr_acc", 32'(o_valid_max), 32'd1);
    check("perr_pre", 32'(o_proto_err), 32'd0);
    tick(); settle();
    check("perr_set", 32'(o_proto_err), 32'd1);
    tick(); settle();
    check("perr_sticky", 32'(o_proto_err), 32'd1);
    rst_n = 1'b0; settle();
    check("mrst_err", 32'(o_proto_err), 32'd0);
    check("mrst_rdy", 32'(req_ready), 32'd0);
    tick();
    tick(); rst_n = 1'b1; req_valid = 2'b10; settle();
    check("mrst_unlock", 32'(req_ready), 32'd2);
    tick(); req_valid = 2'b00;
    push_x(t, 0); push_x(t + 1, 0); push_x(t + 2, 0); push_x(t + 5, 1);
    push_r(t + 17, 1, 16'h00B1);
    run(14);
    compare_logs("perr");
    check("end_noerr", 32'(o_proto_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
